// File: rtl/lightbike_keys_pkg.sv
// Shared scan-code constants, direction encoding and keyset tables
// for the lightbike PS/2 input path.
package lightbike_keys_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_ESC = 8'h76;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Each keyset packs its codes as {left, right, up, down}
    localparam logic [31:0] KEYSET_1 = {8'h1C, 8'h23, 8'h1D, 8'h1B};
    localparam logic [31:0] KEYSET_2 = {8'h2B, 8'h33, 8'h2C, 8'h34};
    localparam logic [31:0] KEYSET_3 = {8'h3B, 8'h4B, 8'h43, 8'h42};
    localparam logic [31:0] KEYSET_4 = {8'h6B, 8'h74, 8'h75, 8'h73};
    localparam logic [7:0]  KEY_DIR_ORDER = {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_hit_t;

    function automatic logic keyset_valid(input logic [2:0] keyset);
        return (keyset >= 3'd1) && (keyset <= 3'd4);
    endfunction

    function automatic key_hit_t keyset_lookup(input logic [2:0] keyset, input logic [7:0] code);
        key_hit_t    res;
        logic [31:0] codes;
        res = '0;
        case (keyset)
            3'd1:    codes = KEYSET_1;
            3'd2:    codes = KEYSET_2;
            3'd3:    codes = KEYSET_3;
            3'd4:    codes = KEYSET_4;
            default: codes = '0;
        endcase
        if (keyset_valid(keyset)) begin
            for (int i = 0; i < 4; i++) begin
                if (codes[31 - 8*i -: 8] == code) begin
                    res.hit = 1'b1;
                    res.dir = KEY_DIR_ORDER[7 - 2*i -: 2];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lightbike_turn_queue.sv
// Two-entry turn FIFO for one player; head is the oldest queued turn,
// tail the most recent one (used as the reference for the next turn).
module lightbike_turn_queue (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [1:0] tail,
    output logic [1:0] count
);

    logic [1:0] slot0;
    logic [1:0] slot1;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= 2'd0;
            slot1 <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (pop && (count != 2'd0)) begin
            if (push) begin
                // Simultaneous pop frees a slot, so count is unchanged
                if (count == 2'd2) begin
                    slot0 <= slot1;
                    slot1 <= din;
                end else begin
                    slot0 <= din;
                end
            end else begin
                slot0 <= slot1;
                count <= count - 2'd1;
            end
        end else if (push && (count != 2'd2)) begin
            if (count == 2'd0) begin
                slot0 <= din;
            end else begin
                slot1 <= din;
            end
            count <= count + 2'd1;
        end
    end

    assign head = slot0;
    assign tail = (count == 2'd2) ? slot1 : slot0;

endmodule

// File: rtl/lightbike_input_controller.sv
// PS/2 scan-code decoder and per-player turn sequencing for the lightbike game.
//   state      | meaning
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen, next byte is an extended make code
//   ST_BRK     | F0 seen, next byte is a released key (ignored)
//   ST_EXT_BRK | E0 F0 seen, next byte is a released extended key (ignored)
module lightbike_input_controller
    import lightbike_keys_pkg::*;
#(
    parameter logic [1:0] INIT_DIR_P1   = 2'd1,
    parameter logic [1:0] INIT_DIR_P2   = 2'd3,
    parameter logic [2:0] DEF_KEYSET_P1 = 3'd1,
    parameter logic [2:0] DEF_KEYSET_P2 = 3'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic [2:0] keyset_p1,
    input  logic [2:0] keyset_p2,
    input  logic       game_start,
    input  logic       tick,
    output logic [1:0] dir_p1,
    output logic [1:0] dir_p2,
    output logic       key_conflict,
    output logic       quit_req
);

    dec_state_t state;
    dec_state_t state_nxt;
    logic       make_evt;
    logic       esc_evt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_nxt = ST_BRK;
                    end
                end
                ST_EXT:  state_nxt = (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // game_start swallows any event decoded in the same cycle
    always_comb begin
        make_evt = 1'b0;
        esc_evt  = 1'b0;
        if (scan_valid && !game_start) begin
            case (state)
                ST_IDLE: begin
                    make_evt = (scan_code != SC_EXT) && (scan_code != SC_BRK);
                    esc_evt  = (scan_code == SC_ESC);
                end
                ST_EXT:  make_evt = (scan_code != SC_BRK);
                default: ;
            endcase
        end
    end

    logic [2:0] ks_p1;
    logic [2:0] ks_p2;

    always_ff @(posedge clock) begin
        if (reset) begin
            ks_p1        <= DEF_KEYSET_P1;
            ks_p2        <= DEF_KEYSET_P2;
            key_conflict <= 1'b0;
            quit_req     <= 1'b0;
        end else begin
            quit_req <= esc_evt;
            if (game_start) begin
                ks_p1        <= keyset_p1;
                ks_p2        <= keyset_p2;
                key_conflict <= (keyset_p1 == keyset_p2) && keyset_valid(keyset_p1);
            end
        end
    end

    key_hit_t   hit_p1, hit_p2;
    logic       turn_p1, turn_p2;
    logic [1:0] head_p1, tail_p1, cnt_p1, ref_dir_p1;
    logic [1:0] head_p2, tail_p2, cnt_p2, ref_dir_p2;
    logic       push_p1, pop_p1, push_p2, pop_p2;

    assign hit_p1  = keyset_lookup(ks_p1, scan_code);
    assign hit_p2  = keyset_lookup(ks_p2, scan_code);
    assign turn_p1 = make_evt && hit_p1.hit;
    assign turn_p2 = make_evt && hit_p2.hit && !key_conflict;

    // Reference is the newest pending turn, evaluated before any pop
    assign ref_dir_p1 = (cnt_p1 != 2'd0) ? tail_p1 : dir_p1;
    assign ref_dir_p2 = (cnt_p2 != 2'd0) ? tail_p2 : dir_p2;

    assign pop_p1 = tick && !game_start && (cnt_p1 != 2'd0);
    assign pop_p2 = tick && !game_start && (cnt_p2 != 2'd0);

    assign push_p1 = turn_p1 && (hit_p1.dir != ref_dir_p1)
                   && (hit_p1.dir != (ref_dir_p1 ^ 2'd2))
                   && ((cnt_p1 != 2'd2) || pop_p1);
    assign push_p2 = turn_p2 && (hit_p2.dir != ref_dir_p2)
                   && (hit_p2.dir != (ref_dir_p2 ^ 2'd2))
                   && ((cnt_p2 != 2'd2) || pop_p2);

    lightbike_turn_queue u_queue_p1 (
        .clock (clock),
        .reset (reset),
        .flush (game_start),
        .push  (push_p1),
        .pop   (pop_p1),
        .din   (hit_p1.dir),
        .head  (head_p1),
        .tail  (tail_p1),
        .count (cnt_p1)
    );

    lightbike_turn_queue u_queue_p2 (
        .clock (clock),
        .reset (reset),
        .flush (game_start),
        .push  (push_p2),
        .pop   (pop_p2),
        .din   (hit_p2.dir),
        .head  (head_p2),
        .tail  (tail_p2),
        .count (cnt_p2)
    );

    always_ff @(posedge clock) begin
        if (reset || game_start) begin
            dir_p1 <= INIT_DIR_P1;
            dir_p2 <= INIT_DIR_P2;
        end else begin
            if (pop_p1) begin
                dir_p1 <= head_p1;
            end
            if (pop_p2) begin
                dir_p2 <= head_p2;
            end
        end
    end

endmodule

// File: tb/tb_lightbike_input_controller.sv
// Directed and randomized checks of the lightbike input controller against
// a rule-level model of key decoding and per-player turn queues.
module tb_lightbike_input_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [2:0] keyset_p1 = 3'd1;
    logic [2:0] keyset_p2 = 3'd4;
    logic       game_start = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_p1, dir_p2;
    logic       key_conflict, quit_req;

    int total = 0;
    int bad = 0;

    lightbike_input_controller dut (
        .clock        (clock),
        .reset        (reset),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .keyset_p1    (keyset_p1),
        .keyset_p2    (keyset_p2),
        .game_start   (game_start),
        .tick         (tick),
        .dir_p1       (dir_p1),
        .dir_p2       (dir_p2),
        .key_conflict (key_conflict),
        .quit_req     (quit_req)
    );

    always #5 clock = ~clock;

    // Reference model state
    int m_dir [2];
    int m_q   [2][2];
    int m_qlen[2];
    int m_ks  [2];
    bit m_conf, m_quit, m_ext, m_brk;

    function automatic int model_dir(int ks, int code);
        int tbl[4][4];
        int dirs[4];
        tbl  = '{'{'h1C, 'h23, 'h1D, 'h1B}, '{'h2B, 'h33, 'h2C, 'h34},
                 '{'h3B, 'h4B, 'h43, 'h42}, '{'h6B, 'h74, 'h75, 'h73}};
        dirs = '{3, 1, 0, 2};
        if (ks < 1 || ks > 4) return -1;
        for (int i = 0; i < 4; i++) begin
            if (tbl[ks-1][i] == code) return dirs[i];
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_dir  = '{1, 3};
        m_qlen = '{0, 0};
        m_ks   = '{1, 4};
        m_conf = 0; m_quit = 0; m_ext = 0; m_brk = 0;
    endfunction

    function automatic void model_step(bit gs, bit tk, bit sv, int sc, int k1, int k2);
        bit make = 0;
        bit esc = 0;
        int d[2];
        int refd;
        bit pop, push;
        if (sv) begin
            if (m_brk) begin
                m_brk = 0; m_ext = 0;
            end else if (sc == 'hF0) begin
                m_brk = 1;
            end else if (sc == 'hE0 && !m_ext) begin
                m_ext = 1;
            end else begin
                make = 1; esc = (sc == 'h76) && !m_ext; m_ext = 0;
            end
        end
        m_quit = esc && !gs;
        if (gs) begin
            m_ks   = '{k1, k2};
            m_conf = (k1 == k2) && k1 >= 1 && k1 <= 4;
            m_dir  = '{1, 3};
            m_qlen = '{0, 0};
            return;
        end
        d[0] = make ? model_dir(m_ks[0], sc) : -1;
        d[1] = (make && !m_conf) ? model_dir(m_ks[1], sc) : -1;
        for (int p = 0; p < 2; p++) begin
            pop  = tk && m_qlen[p] > 0;
            refd = (m_qlen[p] > 0) ? m_q[p][m_qlen[p]-1] : m_dir[p];
            push = d[p] >= 0 && d[p] != refd && d[p] != (refd ^ 2) && (m_qlen[p] < 2 || pop);
            if (pop) begin
                m_dir[p] = m_q[p][0];
                m_q[p][0] = m_q[p][1];
                m_qlen[p]--;
            end
            if (push) begin
                m_q[p][m_qlen[p]] = d[p];
                m_qlen[p]++;
            end
        end
    endfunction

    task automatic step(input bit rs, input bit gs, input bit tk, input bit sv, input logic [7:0] sc);
        reset = rs; game_start = gs; tick = tk; scan_valid = sv; scan_code = sc;
        @(posedge clock);
        if (rs) model_reset();
        else model_step(gs, tk, sv, int'(sc), int'(keyset_p1), int'(keyset_p2));
        #1;
        reset = 0; game_start = 0; tick = 0; scan_valid = 0;
    endtask

    task automatic send(input logic [7:0] sc);
        step(0, 0, 0, 1, sc);
    endtask

    task automatic do_tick();
        step(0, 0, 1, 0, 8'h00);
    endtask

    task automatic start(input logic [2:0] k1, input logic [2:0] k2);
        keyset_p1 = k1; keyset_p2 = k2;
        step(0, 1, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        total += 4;
        if (dir_p1 !== 2'd1) begin bad++; $display("FAIL reset_dir_p1 got %0d want 1", dir_p1); end
        if (dir_p2 !== 2'd3) begin bad++; $display("FAIL reset_dir_p2 got %0d want 3", dir_p2); end
        if (quit_req !== 1'b0) begin bad++; $display("FAIL reset_quit got %b want 0", quit_req); end
        if (key_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got %b want 0", key_conflict); end
        send(8'h1D);
        do_tick();
        total++;
        if (dir_p1 !== 2'd0) begin bad++; $display("FAIL reset_first_turn got %0d want 0", dir_p1); end
    endtask

    task automatic test_break();
        start(3'd1, 3'd4);
        send(8'h1D); send(8'hF0); send(8'h1D);
        do_tick();
        total++;
        if (dir_p1 !== 2'd0) begin bad++; $display("FAIL break_turn got %0d want 0", dir_p1); end
        do_tick();
        total++;
        if (dir_p1 !== 2'd0) begin bad++; $display("FAIL break_no_entry got %0d want 0", dir_p1); end
    endtask

    task automatic test_reversal();
        start(3'd1, 3'd4);
        send(8'h1C); send(8'h23);
        do_tick();
        total++;
        if (dir_p1 !== 2'd1) begin bad++; $display("FAIL reversal_dropped got %0d want 1", dir_p1); end
        send(8'h1D);
        do_tick();
        total++;
        if (dir_p1 !== 2'd0) begin bad++; $display("FAIL reversal_queue_empty got %0d want 0", dir_p1); end
    endtask

    task automatic test_queue_full();
        start(3'd1, 3'd4);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h74); send(8'h73);
        do_tick();
        total++;
        if (dir_p2 !== 2'd0) begin bad++; $display("FAIL full_pop1 got %0d want 0", dir_p2); end
        do_tick();
        total++;
        if (dir_p2 !== 2'd1) begin bad++; $display("FAIL full_pop2 got %0d want 1", dir_p2); end
        do_tick();
        total++;
        if (dir_p2 !== 2'd1) begin bad++; $display("FAIL full_dropped got %0d want 1", dir_p2); end
    endtask

    task automatic test_push_pop_same();
        start(3'd1, 3'd4);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h74);
        step(0, 0, 1, 1, 8'h73);
        total++;
        if (dir_p2 !== 2'd0) begin bad++; $display("FAIL pushpop_dir got %0d want 0", dir_p2); end
        do_tick();
        total++;
        if (dir_p2 !== 2'd1) begin bad++; $display("FAIL pushpop_head got %0d want 1", dir_p2); end
        do_tick();
        total++;
        if (dir_p2 !== 2'd2) begin bad++; $display("FAIL pushpop_tail got %0d want 2", dir_p2); end
        send(8'hE0); send(8'h74);
        start(3'd2, 3'd2);
        total += 2;
        if (key_conflict !== 1'b1) begin bad++; $display("FAIL conflict_set got %b want 1", key_conflict); end
        if (dir_p2 !== 2'd3) begin bad++; $display("FAIL start_reload got %0d want 3", dir_p2); end
        send(8'h2C);
        do_tick();
        total += 2;
        if (dir_p1 !== 2'd0) begin bad++; $display("FAIL conflict_p1 got %0d want 0", dir_p1); end
        if (dir_p2 !== 2'd3) begin bad++; $display("FAIL conflict_p2 got %0d want 3", dir_p2); end
    endtask

    task automatic test_quit();
        logic seen;
        seen = 0;
        send(8'hF0); seen |= quit_req;
        send(8'h76); seen |= quit_req;
        send(8'hE0); seen |= quit_req;
        send(8'h76); seen |= quit_req;
        step(0, 0, 0, 0, 8'h00); seen |= quit_req;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL quit_prefixed got %b want 0", seen); end
        send(8'h76);
        total++;
        if (quit_req !== 1'b1) begin bad++; $display("FAIL quit_pulse got %b want 1", quit_req); end
        step(0, 0, 0, 0, 8'h00);
        total++;
        if (quit_req !== 1'b0) begin bad++; $display("FAIL quit_one_cycle got %b want 0", quit_req); end
        send(8'hE0);
        step(1, 0, 0, 0, 8'h00);
        send(8'h76);
        total++;
        if (quit_req !== 1'b1) begin bad++; $display("FAIL reset_clears_prefix got %b want 1", quit_req); end
        send(8'h75);
        do_tick();
        total++;
        if (dir_p2 !== 2'd0) begin bad++; $display("FAIL keypad_up got %0d want 0", dir_p2); end
    endtask

    task automatic test_random();
        logic [7:0] pool[19];
        logic [7:0] sc;
        int         sel;
        bit         rs, gs, tk, sv;
        pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2B, 8'h33, 8'h2C, 8'h34, 8'h3B, 8'h4B,
                 8'h43, 8'h42, 8'h6B, 8'h74, 8'h75, 8'h73, 8'hE0, 8'hF0, 8'h76};
        step(1, 0, 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            rs  = ($urandom_range(0, 299) == 0);
            gs  = ($urandom_range(0, 59) == 0);
            tk  = ($urandom_range(0, 3) == 0);
            sv  = ($urandom_range(0, 1) == 0);
            sel = $urandom_range(0, 24);
            sc  = (sel < 19) ? pool[sel] : 8'($urandom);
            if (gs) begin
                keyset_p1 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
                keyset_p2 = ($urandom_range(0, 3) == 0) ? keyset_p1 : 3'($urandom_range(1, 4));
            end
            step(rs, gs, tk, sv, sc);
            total += 4;
            if (dir_p1 !== 2'(m_dir[0])) begin
                bad++; $display("FAIL rand_dir_p1 cycle %0d got %0d want %0d", n, dir_p1, m_dir[0]);
            end
            if (dir_p2 !== 2'(m_dir[1])) begin
                bad++; $display("FAIL rand_dir_p2 cycle %0d got %0d want %0d", n, dir_p2, m_dir[1]);
            end
            if (key_conflict !== m_conf) begin
                bad++; $display("FAIL rand_conflict cycle %0d got %b want %b", n, key_conflict, m_conf);
            end
            if (quit_req !== m_quit) begin
                bad++; $display("FAIL rand_quit cycle %0d got %b want %b", n, quit_req, m_quit);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_break();
        test_reversal();
        test_queue_full();
        test_push_pop_same();
        test_quit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
